servo_dispenser_multi: RTL and testbench
========================================

Name: servo_dispenser_multi

Overview:
- Parametrised N-channel successor to the single-servo candy dispenser controller.
- Each channel:
  - debounces a photoresistor input,
  - decides a retracted/extended target,
  - drives a hobby-servo PWM pulse train for a bounded travel time, then goes quiet.
- Adds homing after reset, per-channel enable, busy/done status, and a status LED whose blink rate encodes activity.
- Sits at the top level between board pins and servo headers; all logic runs on one clock using tick enables.

Parameters:
- CHANNELS, 2, number of sensor/servo pairs.
- CLK_DIV, 50, clk_50m cycles per 1 us tick.
- RETRACT_US, 1000, pulse width for the retracted position, in us.
- EXTEND_US, 2000, pulse width for the extended position, in us.
- FRAME_US, 16000, PWM frame period, in us. Must exceed EXTEND_US.
- TRAVEL_MS, 1000, time pulses are sent per move, in ms.
- DEB_MAX, 1000, debounce integrator ceiling.
- DEB_THRESH, 750, integrator level strictly above which the sensor counts as active.
- LED_HALF_MS, 500, LED half-period when idle. Busy half-period is LED_HALF_MS/4.

Ports:
- clk_50m  in  1  sole clock.
- rst_n  in  1  asynchronous, active-low reset.
- sensor  in  CHANNELS  raw photoresistor inputs, asynchronous.
- chan_en  in  CHANNELS  per-channel enable, synchronous to clk_50m.
- servo  out  CHANNELS  PWM outputs, registered.
- busy  out  CHANNELS  high while a channel is homing or moving, registered.
- done  out  CHANNELS  one-clk pulse when a move completes, registered.
- led  out  1  status blink, registered.

Behaviour:
- Reset (rst_n low, asynchronous): all counters 0, all FSMs in HOME, pos=0. Outputs during reset: servo=0, busy=0, done=0, led=0.
- Ticks:
  - us_tick: one-clk pulse when the divider reaches CLK_DIV-1; the divider then wraps to 0.
  - ms_tick: one-clk pulse coincident with every 1000th us_tick.
  - First us_tick occurs CLK_DIV clks after reset release.
- Sensor path:
  - Each sensor bit passes through a 2-FF synchroniser; the value is usable 2 clks later.
  - Integrator lvl (width clog2(DEB_MAX+1)) updates on ms_tick only:
    - +1 if sync=1 and lvl<DEB_MAX;
    - -1 if sync=0 and lvl>0;
    - saturates at both ends.
  - deb <= (lvl > DEB_THRESH), registered on ms_tick. Steady high input asserts deb after DEB_THRESH+2 ms_ticks.
- Per-channel FSM (HOME, IDLE, MOVING), evaluated on ms_tick unless noted:
  - HOME: when chan_en=1, set pos=0, travel=TRAVEL_MS, frame=0, go to MOVING. Homing happens exactly once per reset.
  - IDLE: when chan_en=1 and deb!=pos, set pos=deb, travel=TRAVEL_MS, frame=0, go to MOVING. When chan_en=0, stay in IDLE.
  - MOVING: travel decrements each ms_tick. On the ms_tick where travel==1, go to IDLE and pulse done for exactly 1 clk.
  - deb changes during MOVING are ignored. They are re-evaluated on the first ms_tick after returning to IDLE.
  - chan_en=0 in any state (checked every clk): go to IDLE next clk and drop servo next clk (pulse truncation allowed); pos keeps its new value; no done pulse. A channel in HOME that is disabled stays in HOME.
- PWM (MOVING only):
  - frame counts us_ticks from 0 to FRAME_US-1, then wraps.
  - servo = (frame < width), width = pos ? EXTEND_US : RETRACT_US.
  - Each pulse is width us ±1 clk.
  - A pulse in progress at move end completes normally; servo stays 0 in IDLE/HOME after that.
  - The first pulse of a move begins within 1 us_tick of entering MOVING.
- busy: 1 exactly while the state is MOVING.
- LED: toggles every LED_HALF_MS ms_ticks when no busy bit is set, every LED_HALF_MS/4 when any is set. Its counter restarts at 0 on rate change.
- Channels are fully independent and may be in simultaneous moves. Arithmetic never wraps except the divider and frame counters.

Test Plan (simulations may override CLK_DIV=2, TRAVEL_MS=20, FRAME_US=5000, DEB_THRESH=6, DEB_MAX=8):
- Reset release, chan_en=all 1, sensor=0 -> each channel: busy rises on the first ms_tick; 1000 us pulses repeat every 5000 us; busy falls after 20 ms; done pulses for 1 clk; servo stays 0 afterwards.
- Homing done, sensor[0] held 1 -> deb[0]=1 after 8 ms_ticks; channel 0 moves with 2000 us pulses for 20 ms; channel 1 shows no activity.
- sensor[0] toggling 1/0 every ms -> lvl stays ≤1, deb never asserts, no move.
- sensor[0] drops to 0 mid-move, fully debounced -> current move finishes at 2000 us; a retract move starts on the first ms_tick in IDLE.
- chan_en[1] cleared mid-pulse during a move -> servo[1]=0 and busy[1]=0 next clk; no done pulse; re-enable with deb equal to pos gives no move.
- rst_n asserted mid-pulse -> servo=0 immediately (asynchronous); after release, channels home again.

Source files
------------

// File: rtl/servo_dispenser_multi.sv
// N-channel candy dispenser: per-channel sensor debounce, home/idle/move FSM and
// servo PWM, sharing one us/ms tick generator and a busy-rate status LED.

module servo_dispenser_chan #(
    parameter int RETRACT_US = 1000,
    parameter int EXTEND_US  = 2000,
    parameter int FRAME_US   = 16000,
    parameter int TRAVEL_MS  = 1000,
    parameter int DEB_MAX    = 1000,
    parameter int DEB_THRESH = 750
) (
    input  logic clk_50m,
    input  logic rst_n,
    input  logic us_tick,
    input  logic ms_tick,
    input  logic sensor,
    input  logic chan_en,
    output logic servo,
    output logic busy,
    output logic done
);
    localparam int LVL_W = $clog2(DEB_MAX + 1);
    localparam int FRM_W = $clog2(FRAME_US);
    localparam int TRV_W = $clog2(TRAVEL_MS + 1);
    localparam logic [LVL_W-1:0] LVL_MAX  = LVL_W'(DEB_MAX);
    localparam logic [LVL_W-1:0] LVL_TH   = LVL_W'(DEB_THRESH);
    localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(FRAME_US - 1);
    localparam logic [FRM_W-1:0] RET_W    = FRM_W'(RETRACT_US);
    localparam logic [FRM_W-1:0] EXT_W    = FRM_W'(EXTEND_US);
    localparam logic [TRV_W-1:0] TRV_INIT = TRV_W'(TRAVEL_MS);
    localparam logic [TRV_W-1:0] TRV_ONE  = TRV_W'(1);

    localparam logic [1:0] ST_HOME   = 2'd0;
    localparam logic [1:0] ST_IDLE   = 2'd1;
    localparam logic [1:0] ST_MOVING = 2'd2;

    logic [1:0]       sync;
    logic [LVL_W-1:0] lvl;
    logic             deb;
    logic [1:0]       state, state_nxt;
    logic             pos, pos_nxt;
    logic             tail, tail_nxt;
    logic             done_nxt, start;
    logic [FRM_W-1:0] frame, frame_nxt, width;
    logic [TRV_W-1:0] travel, travel_nxt;

    assign width = pos ? EXT_W : RET_W;

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            sync <= '0;
            lvl  <= '0;
            deb  <= 1'b0;
        end else begin
            sync <= {sync[0], sensor};
            if (ms_tick) begin
                if (sync[1] && lvl != LVL_MAX)
                    lvl <= lvl + 1'b1;
                else if (!sync[1] && lvl != '0)
                    lvl <= lvl - 1'b1;
                deb <= (lvl > LVL_TH);
            end
        end
    end

    // tail keeps the frame running after a move ends so an in-flight pulse finishes
    always_comb begin
        state_nxt  = state;
        pos_nxt    = pos;
        travel_nxt = travel;
        frame_nxt  = frame;
        tail_nxt   = tail;
        done_nxt   = 1'b0;
        start      = 1'b0;
        if ((state == ST_MOVING || tail) && us_tick)
            frame_nxt = (frame == FRM_LAST) ? '0 : frame + 1'b1;
        if (tail && frame >= width)
            tail_nxt = 1'b0;
        if (!chan_en) begin
            tail_nxt = 1'b0;
            if (state != ST_HOME)
                state_nxt = ST_IDLE;
        end else if (ms_tick) begin
            case (state)
                ST_HOME: begin
                    start   = 1'b1;
                    pos_nxt = 1'b0;
                end
                ST_IDLE: begin
                    if (deb != pos) begin
                        start   = 1'b1;
                        pos_nxt = deb;
                    end
                end
                ST_MOVING: begin
                    if (travel == TRV_ONE) begin
                        state_nxt = ST_IDLE;
                        done_nxt  = 1'b1;
                        tail_nxt  = servo;
                    end else begin
                        travel_nxt = travel - 1'b1;
                    end
                end
                default: state_nxt = ST_HOME;
            endcase
        end
        if (start) begin
            state_nxt  = ST_MOVING;
            travel_nxt = TRV_INIT;
            frame_nxt  = '0;
            tail_nxt   = 1'b0;
        end
    end

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_HOME;
            pos    <= 1'b0;
            tail   <= 1'b0;
            frame  <= '0;
            travel <= '0;
            servo  <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= state_nxt;
            pos    <= pos_nxt;
            tail   <= tail_nxt;
            frame  <= frame_nxt;
            travel <= travel_nxt;
            servo  <= chan_en && (state == ST_MOVING || tail) && (frame < width);
            busy   <= (state_nxt == ST_MOVING);
            done   <= done_nxt;
        end
    end
endmodule

module servo_dispenser_multi #(
    parameter int CHANNELS    = 2,
    parameter int CLK_DIV     = 50,
    parameter int RETRACT_US  = 1000,
    parameter int EXTEND_US   = 2000,
    parameter int FRAME_US    = 16000,
    parameter int TRAVEL_MS   = 1000,
    parameter int DEB_MAX     = 1000,
    parameter int DEB_THRESH  = 750,
    parameter int LED_HALF_MS = 500
) (
    input  logic                clk_50m,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] sensor,
    input  logic [CHANNELS-1:0] chan_en,
    output logic [CHANNELS-1:0] servo,
    output logic [CHANNELS-1:0] busy,
    output logic [CHANNELS-1:0] done,
    output logic                led
);
    localparam int DIV_W       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int LED_BUSY_MS = (LED_HALF_MS / 4 > 0) ? LED_HALF_MS / 4 : 1;
    localparam int LED_W       = (LED_HALF_MS > 1) ? $clog2(LED_HALF_MS + 1) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST      = DIV_W'(CLK_DIV - 1);
    localparam logic [LED_W-1:0] LED_IDLE_LAST = LED_W'(LED_HALF_MS - 1);
    localparam logic [LED_W-1:0] LED_BUSY_LAST = LED_W'(LED_BUSY_MS - 1);

    logic [DIV_W-1:0] div;
    logic [9:0]       us_cnt;
    logic             us_tick, ms_tick;
    logic [LED_W-1:0] led_cnt, led_last;
    logic             any_busy, busy_q;

    // ms_tick is raised on the same edge as its us_tick so the two stay coincident
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            div     <= '0;
            us_cnt  <= '0;
            us_tick <= 1'b0;
            ms_tick <= 1'b0;
        end else begin
            us_tick <= 1'b0;
            ms_tick <= 1'b0;
            if (div == DIV_LAST) begin
                div     <= '0;
                us_tick <= 1'b1;
                if (us_cnt == 10'd999) begin
                    us_cnt  <= '0;
                    ms_tick <= 1'b1;
                end else begin
                    us_cnt <= us_cnt + 1'b1;
                end
            end else begin
                div <= div + 1'b1;
            end
        end
    end

    assign any_busy = |busy;
    assign led_last = any_busy ? LED_BUSY_LAST : LED_IDLE_LAST;

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            led_cnt <= '0;
            busy_q  <= 1'b0;
            led     <= 1'b0;
        end else begin
            busy_q <= any_busy;
            if (any_busy != busy_q) begin
                led_cnt <= '0;
            end else if (ms_tick) begin
                if (led_cnt >= led_last) begin
                    led_cnt <= '0;
                    led     <= ~led;
                end else begin
                    led_cnt <= led_cnt + 1'b1;
                end
            end
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        servo_dispenser_chan #(
            .RETRACT_US (RETRACT_US),
            .EXTEND_US  (EXTEND_US),
            .FRAME_US   (FRAME_US),
            .TRAVEL_MS  (TRAVEL_MS),
            .DEB_MAX    (DEB_MAX),
            .DEB_THRESH (DEB_THRESH)
        ) u_chan (
            .clk_50m (clk_50m),
            .rst_n   (rst_n),
            .us_tick (us_tick),
            .ms_tick (ms_tick),
            .sensor  (sensor[g]),
            .chan_en (chan_en[g]),
            .servo   (servo[g]),
            .busy    (busy[g]),
            .done    (done[g])
        );
    end
endmodule

// File: tb/tb_servo_dispenser_multi.sv
// Scoreboard bench: stimulus pushes expected pulse/done events per channel,
// a negedge monitor pops and compares them as servo pulses end and done fires.

module tb_servo_dispenser_multi;
    localparam int CD   = 2;
    localparam int RET  = 500;
    localparam int EXT  = 1000;
    localparam int FRM  = 1200;
    localparam int TRV  = 3;
    localparam int DMAX = 4;
    localparam int DTH  = 2;
    localparam int LEDH = 4;

    logic       clk_50m = 1'b0;
    logic       rst_n   = 1'b0;
    logic [1:0] sensor  = 2'b00;
    logic [1:0] chan_en = 2'b11;
    logic [1:0] servo, busy, done;
    logic       led;

    int n_chk  = 0;
    int n_pass = 0;
    int hi_cnt [2] = '{0, 0};

    typedef struct {
        bit is_done;
        bit trunc;
        int clks;
    } ev_t;
    ev_t q0[$];
    ev_t q1[$];

    servo_dispenser_multi #(
        .CHANNELS(2), .CLK_DIV(CD), .RETRACT_US(RET), .EXTEND_US(EXT),
        .FRAME_US(FRM), .TRAVEL_MS(TRV), .DEB_MAX(DMAX), .DEB_THRESH(DTH),
        .LED_HALF_MS(LEDH)
    ) dut (
        .clk_50m (clk_50m),
        .rst_n   (rst_n),
        .sensor  (sensor),
        .chan_en (chan_en),
        .servo   (servo),
        .busy    (busy),
        .done    (done),
        .led     (led)
    );

    always #5 clk_50m = ~clk_50m;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    endtask

    task automatic push(input int ch, input bit d, input bit t, input int c);
        ev_t e;
        e.is_done = d;
        e.trunc   = t;
        e.clks    = c;
        if (ch == 0) q0.push_back(e);
        else         q1.push_back(e);
    endtask

    // three pulses per move; with tail the last one finishes after done
    task automatic push_move(input int ch, input int w_us, input bit tail);
        push(ch, 1'b0, 1'b0, w_us * CD);
        push(ch, 1'b0, 1'b0, w_us * CD);
        if (tail) begin
            push(ch, 1'b1, 1'b0, 0);
            push(ch, 1'b0, 1'b0, w_us * CD);
        end else begin
            push(ch, 1'b0, 1'b0, w_us * CD);
            push(ch, 1'b1, 1'b0, 0);
        end
    endtask

    task automatic got(input int ch, input bit d, input int c);
        ev_t e;
        bit  have;
        have = (ch == 0) ? (q0.size() > 0) : (q1.size() > 0);
        if (!have) begin
            n_chk++;
            $display("FAIL ch%0d_event: got unexpected %s (clks=%0d), expected none",
                     ch, d ? "done" : "pulse", c);
            return;
        end
        if (ch == 0) e = q0.pop_front();
        else         e = q1.pop_front();
        if (d != e.is_done)
            chk($sformatf("ch%0d_event_kind", ch), int'(d), int'(e.is_done));
        else if (d)
            chk($sformatf("ch%0d_done", ch), 1, 1 - int'(e.trunc));
        else if (e.trunc)
            chk($sformatf("ch%0d_trunc_pulse_short", ch), int'(c > 0 && c < e.clks), 1);
        else
            chk($sformatf("ch%0d_pulse_clks", ch), c, e.clks);
    endtask

    always @(negedge clk_50m) begin
        for (int i = 0; i < 2; i++) begin
            if (servo[i]) hi_cnt[i]++;
            else if (hi_cnt[i] != 0) begin
                got(i, 1'b0, hi_cnt[i]);
                hi_cnt[i] = 0;
            end
            if (done[i]) got(i, 1'b1, 0);
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk_50m);
        @(negedge clk_50m);
    endtask

    task automatic wait_busy(input int ch, input bit lvl, input int max, input string nm);
        int n = 0;
        while (busy[ch] !== lvl && n < max) begin
            @(negedge clk_50m);
            n++;
        end
        chk(nm, int'(busy[ch]), int'(lvl));
    endtask

    task automatic wait_servo(input int ch, input bit lvl, input int max, input string nm);
        int n = 0;
        while (servo[ch] !== lvl && n < max) begin
            @(negedge clk_50m);
            n++;
        end
        chk(nm, int'(servo[ch]), int'(lvl));
    endtask

    initial begin
        int n;
        // reset state
        idle(5);
        chk("rst_servo", servo, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_led", led, 0);

        // homing after release, first ms_tick at clk 2000
        rst_n = 1'b1;
        push_move(0, RET, 1'b0);
        push_move(1, RET, 1'b0);
        idle(1995);
        chk("busy_before_tick", busy, 0);
        idle(15);
        chk("busy_homing", busy, 3);
        idle(2990);
        chk("led_busy_rate_on", led, 1);
        idle(2000);
        chk("led_busy_rate_off", led, 0);
        idle(2000);
        chk("busy_after_home", busy, 0);
        chk("servo_after_home", servo, 0);

        // channel 0 extend, sensor drops mid-move, then retract
        sensor[0] = 1'b1;
        push_move(0, EXT, 1'b1);
        push_move(0, RET, 1'b0);
        wait_busy(0, 1'b1, 12000, "busy0_extend_start");
        chk("busy1_quiet", busy[1], 0);
        sensor[0] = 1'b0;
        wait_busy(0, 1'b0, 8000, "busy0_extend_end");
        wait_busy(0, 1'b1, 3000, "busy0_retract_start");
        wait_busy(0, 1'b0, 8000, "busy0_retract_end");
        idle(500);
        chk("servo0_quiet", servo[0], 0);

        // toggling sensor never debounces
        for (int k = 0; k < 4; k++) begin
            sensor[0] = ~sensor[0];
            idle(2000);
        end
        sensor[0] = 1'b0;
        chk("busy_toggle", busy, 0);

        // disable channel 1 mid-pulse
        sensor[1] = 1'b1;
        wait_busy(1, 1'b1, 14000, "busy1_extend_start");
        wait_servo(1, 1'b1, 100, "servo1_pulse_start");
        idle(100);
        push(1, 1'b0, 1'b1, EXT * CD);
        chan_en[1] = 1'b0;
        idle(1);
        chk("servo1_disabled", servo[1], 0);
        chk("busy1_disabled", busy[1], 0);
        idle(1000);
        chan_en[1] = 1'b1;
        idle(4000);
        chk("busy1_reenable_nomove", busy[1], 0);

        // asynchronous reset mid-pulse, then homing again
        rst_n = 1'b0;
        idle(20);
        rst_n = 1'b1;
        wait_servo(0, 1'b1, 2200, "servo0_rehome_pulse");
        idle(100);
        push(0, 1'b0, 1'b1, RET * CD);
        push(1, 1'b0, 1'b1, RET * CD);
        @(posedge clk_50m);
        #3 rst_n = 1'b0;
        #1;
        chk("servo_async_rst", servo, 0);
        chk("busy_async_rst", busy, 0);
        idle(20);
        rst_n = 1'b1;
        push_move(0, RET, 1'b0);
        push_move(1, RET, 1'b0);
        push_move(1, EXT, 1'b1);

        n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < 25000) begin
            @(negedge clk_50m);
            n++;
        end
        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);
        idle(200);
        chk("busy_final", busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
